// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester. Takes one command at a time
// from a valid/ready port, runs an APB SETUP/ACCESS transfer and returns read
// data plus a completion-or-timeout status as a one-cycle response pulse.
//
// Handshake: a command transfers on a rising PCLK edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so cmd_valid and the
// command fields are ignored while a transfer is in flight. rsp_valid is a
// one-cycle pulse with no back-pressure; rsp_rdata/rsp_err hold until the next
// response.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY
);

    // Encoding chosen so PSEL and PENABLE are single state bits: no decode
    // glitches, PENABLE rises one cycle after PSEL and both fall together.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } state_t;

    // Counter value on the edge that ends the last allowed wait cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       timeout_hit;

    assign accept      = (state == IDLE) && cmd_valid;
    assign timeout_hit = (wait_cnt == TO_LAST);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign PSEL      = state[0];
    assign PENABLE   = state[1];

    // State register; reset drops any transfer in flight immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> SETUP -> ACCESS (waits on PREADY) -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (PREADY || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command capture, wait counting and response generation.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE    <= 1'b0;
            PADDR     <= 8'h00;
            PWDATA    <= 8'h00;
            wait_cnt  <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                PWRITE   <= cmd_write;
                PADDR    <= cmd_addr;
                PWDATA   <= cmd_wdata;
                wait_cnt <= 8'h00;
            end else if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= PWRITE ? 8'h00 : PRDATA;
                end else if (timeout_hit) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 8'h00;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: directed transfers with hand-computed responses,
// a response scoreboard fed by the driver and drained by a monitor.
module tb_apb_master;

    logic       PCLK;
    logic       PRESETn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;

    // Expected response: {rsp_err, rsp_rdata}
    logic [8:0] exp_q[$];

    apb_master #(.TIMEOUT_CYCLES(15)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    // Clock block
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge PCLK) begin
        if (PRESETn && rsp_valid) begin
            rsp_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: act err=%0b rdata=0x%02h req=no response", rsp_err, rsp_rdata);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    errors++;
                    $display("FAIL rsp_data: act err=%0b rdata=0x%02h req err=%0b rdata=0x%02h",
                             rsp_err, rsp_rdata, e[8], e[7:0]);
                end
            end
        end
    end

    // Driver: one transfer. wait_n = PREADY-low ACCESS cycles before PREADY rises.
    task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int wait_n, input logic [7:0] rd,
                            input logic [8:0] exp_rsp, input int exp_n);
        int n;
        @(negedge PCLK);
        chk("idle_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        PREADY    = 1'b0;
        PRDATA    = rd;
        exp_q.push_back(exp_rsp);
        @(posedge PCLK);  // E0: accept
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = ~a;   // fields must already be captured
        cmd_wdata = ~d;
        cmd_write = ~w;
        chk("setup_psel_pen", {PSEL, PENABLE, cmd_ready, busy}, 4'b1001);
        chk("setup_fields", {PWRITE, PADDR, PWDATA}, {w, a, d});
        @(posedge PCLK);  // E1: enter ACCESS
        #1;
        chk("access_psel_pen", {PSEL, PENABLE}, 2'b11);
        n = 1;
        PREADY = (n > wait_n);
        for (int k = 0; k < 300; k++) begin
            @(posedge PCLK);
            #1;
            if (rsp_valid || !busy) break;
            chk("access_hold", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {2'b11, w, a, d});
            n++;
            PREADY = (n > wait_n);
        end
        PREADY = 1'b0;
        chk("access_cycles", n, exp_n);
        chk("done_state", {rsp_valid, PSEL, PENABLE, cmd_ready, busy}, 5'b10010);
        chk("done_hold", {PWRITE, PADDR, PWDATA}, {w, a, d});
        @(posedge PCLK);
        #1;
        chk("rsp_pulse_low", rsp_valid, 1'b0);
        chk("rsp_hold", {rsp_err, rsp_rdata}, exp_rsp);
    endtask

    // Address/data table for the back-to-back writes
    logic [7:0] b2b_addr[4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    logic [7:0] b2b_data[4] = '{8'h01, 8'h02, 8'h04, 8'h08};

    initial begin
        int k;
        int cyc;
        int last_cyc;
        int seen0;

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        PRDATA    = 8'h00;
        PREADY    = 1'b0;
        #23;
        chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err},
            30'h0);
        chk("reset_ready_busy", {cmd_ready, busy}, 2'b10);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Zero-wait write
        run_xfer(1'b1, 8'h0F, 8'hA5, 0, 8'hEE, {1'b0, 8'h00}, 1);
        // Read with 3 wait cycles
        run_xfer(1'b0, 8'h0F, 8'h00, 3, 8'h3C, {1'b0, 8'h3C}, 4);
        // Write with waits: rdata must be 0 even with PRDATA driven
        run_xfer(1'b1, 8'h22, 8'h11, 2, 8'hFF, {1'b0, 8'h00}, 3);
        // Timeout: PREADY never rises
        run_xfer(1'b0, 8'h55, 8'h00, 1000, 8'h77, {1'b1, 8'h00}, 15);
        // PREADY rises on the 15th ACCESS edge: normal completion wins
        run_xfer(1'b0, 8'h66, 8'h00, 14, 8'h5A, {1'b0, 8'h5A}, 15);

        // Back-to-back writes with cmd_valid held high and a zero-wait completer
        @(negedge PCLK);
        seen0     = rsp_seen;
        PREADY    = 1'b1;
        k         = 0;
        cyc       = 0;
        last_cyc  = -1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = b2b_addr[0];
        cmd_wdata = b2b_data[0];
        exp_q.push_back(9'h000);
        while (k < 4 && cyc < 60) begin
            @(posedge PCLK);
            #1;
            cyc++;
            if (PSEL && !PENABLE) begin
                chk("b2b_addr", {PADDR, PWDATA}, {b2b_addr[k], b2b_data[k]});
                if (last_cyc >= 0) chk("b2b_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                k++;
                if (k < 4) begin
                    cmd_addr  = b2b_addr[k];
                    cmd_wdata = b2b_data[k];
                    exp_q.push_back(9'h000);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", k, 4);
        repeat (5) @(posedge PCLK);
        #1;
        PREADY = 1'b0;
        chk("b2b_pulses", rsp_seen - seen0, 4);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Reset in the middle of ACCESS: transfer dropped, no response
        @(negedge PCLK);
        seen0     = rsp_seen;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0F;
        PREADY    = 1'b0;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        @(posedge PCLK);
        #1;
        chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("reset_mid_psel_pen", {PSEL, PENABLE, busy, rsp_valid}, 4'b0000);
        @(negedge PCLK);
        PREADY  = 1'b1;
        PRESETn = 1'b1;
        #1;
        chk("reset_release_ready", cmd_ready, 1'b1);
        repeat (4) @(posedge PCLK);
        #1;
        PREADY = 1'b0;
        chk("reset_no_rsp", rsp_seen - seen0, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers toward 8-bit peripherals such as the GPIO block. It sits between on-chip control logic (test sequencer, CPU-side glue) and the APB bus. It returns read data and a completion or timeout status for every accepted command.

## Interface
- TIMEOUT_CYCLES, 15, number of ACCESS cycles with PREADY low before abort; legal range 1..255

- PCLK  input  1  bus clock; all logic on rising edge
- PRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  8  target address
- cmd_wdata  input  8  write data
- rsp_valid  output  1  one-cycle pulse: command finished
- rsp_rdata  output  8  read data (0 for writes and timeouts)
- rsp_err  output  1  valid with rsp_valid; 1 = timeout abort
- busy  output  1  transfer in progress (state != IDLE)
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  8  APB address
- PWDATA  output  8  APB write data
- PRDATA  input  8  APB read data
- PREADY  input  1  APB completer ready

## Operation
- Reset (asynchronous, immediate): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, timeout counter = 0; cmd_ready = 1; busy = 0.
- FSM: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE: cmd_ready = 1, PSEL = 0, PENABLE = 0. On cmd_valid && cmd_ready at an edge: register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, clear counter, go SETUP.
- SETUP (exactly one cycle): PSEL = 1, PENABLE = 0, cmd_ready = 0. Go ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1. At each edge:
  - PREADY = 1: complete. Read: rsp_rdata <= PRDATA; write: rsp_rdata <= 0. rsp_err <= 0, rsp_valid <= 1, go IDLE.
  - PREADY = 0, counter = TIMEOUT_CYCLES-1: abort. rsp_rdata <= 0, rsp_err <= 1, rsp_valid <= 1, go IDLE.
  - else counter <= counter + 1 (8-bit, never wraps given legal range).
- PWRITE/PADDR/PWDATA stable from SETUP through end of ACCESS; hold last value in IDLE.
- rsp_valid high exactly one cycle; rsp_rdata/rsp_err hold until next response.
- cmd_valid ignored while cmd_ready = 0; command fields sampled only at the accept edge.
- Reset mid-transfer: transfer dropped, no rsp_valid, PSEL/PENABLE low immediately.

## Timing
- Accept at edge E0; SETUP during E0..E1; ACCESS from E1.
- Zero-wait completer (PREADY = 1 in first ACCESS cycle): completion at E2, rsp_valid high E2..E3, cmd_ready high from E2.
- New command accepted at E2 edge is legal only if presented while cmd_ready was high, i.e. earliest at E3; minimum 3 cycles per transfer.
- Each PREADY-low ACCESS cycle adds one cycle.
- Timeout: abort at the edge ending the TIMEOUT_CYCLES-th ACCESS cycle with PREADY low; PREADY sampled high on that same edge wins (normal completion).
- PSEL/PENABLE never glitch: PENABLE rises one cycle after PSEL, both fall together.

## Test plan
- Reset mid-ACCESS (PRESETn low between edges) -> PSEL=PENABLE=0 at once, no rsp_valid, cmd_ready=1 after release.
- Write addr 0x0F data 0xA5, PREADY=1 immediately -> PSEL at E0+, PENABLE at E1+, PADDR=0x0F, PWDATA=0xA5, PWRITE=1 throughout; rsp_valid one cycle at E2, rsp_err=0, rsp_rdata=0x00.
- Read addr 0x0F, PRDATA=0x3C, PREADY low 3 cycles then high -> ACCESS 4 cycles, rsp_rdata=0x3C, rsp_err=0.
- Read with PREADY held low, TIMEOUT_CYCLES=15 -> abort after 15 ACCESS cycles, rsp_err=1, rsp_rdata=0x00, back to IDLE.
- PREADY rises on exactly the 15th ACCESS edge -> normal completion, rsp_err=0.
- cmd_valid held high with 4 back-to-back writes -> each accepted only when cmd_ready=1, exactly 4 rsp_valid pulses, 3-cycle spacing with zero-wait completer.
